// File: rtl/data_bus_arbiter.sv
// Round-robin two-master arbiter for the shared core data bus; a transfer holds data_cs for WAIT_CYCLES clocks and acks one clock later.
// Requests are level-held until ack; a losing request simply stays pending, and there is no other backpressure.
module data_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_wdata,
  input  logic        m0_rw,
  input  logic [1:0]  m0_mode,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_wdata,
  input  logic        m1_rw,
  input  logic [1:0]  m1_mode,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] data_address,
  inout  wire  [31:0] data_bus,
  output logic        data_cs,
  output logic        data_rw,
  output logic [1:0]  data_mode
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wdata;
    logic        rw;
    logic [1:0]  mode;
  } xfer_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             winner_q, winner_d;
  xfer_t            xfer_q, xfer_d;
  logic             cs_q, cs_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;

  xfer_t            m0_xfer, m1_xfer, sel_xfer;
  logic             grant;

  assign m0_xfer  = '{address: m0_address, wdata: m0_wdata, rw: m0_rw, mode: m0_mode};
  assign m1_xfer  = '{address: m1_address, wdata: m1_wdata, rw: m1_rw, mode: m1_mode};

  // Under contention the port that did not win last time gets the bus.
  assign grant    = (m0_req && m1_req) ? ~last_grant_q : m1_req;
  assign sel_xfer = grant ? m1_xfer : m0_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      xfer_q       <= '0;
      cs_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      xfer_q       <= xfer_d;
      cs_q         <= cs_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    xfer_d       = xfer_q;
    cs_d         = cs_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          winner_d = grant;
          xfer_d   = sel_xfer;
          cs_d     = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = BUS;
        end
      end
      BUS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Read data is taken at the final edge of the cs window.
          if (!xfer_q.rw) begin
            if (winner_q) rdata1_d = data_bus;
            else          rdata0_d = data_bus;
          end
          cs_d         = 1'b0;
          ack0_d       = ~winner_q;
          ack1_d       = winner_q;
          last_grant_d = winner_q;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_bus     = (state_q == BUS && cs_q && xfer_q.rw) ? xfer_q.wdata : 32'bz;
  assign data_address = xfer_q.address;
  assign data_rw      = xfer_q.rw;
  assign data_mode    = xfer_q.mode;
  assign data_cs      = cs_q;
  assign m0_ack       = ack0_q;
  assign m1_ack       = ack1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: one instance at WAIT_CYCLES=1, one at WAIT_CYCLES=3.
module tb_data_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   both_ack_cnt;
  int   print_cnt;
  logic [7:0] print_chr;
  logic stop_seen;

  // WAIT_CYCLES=1 instance
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata;
  logic [1:0]  m0_mode, m1_mode;
  logic [31:0] m0_rdata, m1_rdata, data_address;
  logic        m0_ack, m1_ack, data_cs, data_rw;
  logic [1:0]  data_mode;
  wire  [31:0] data_bus;
  logic        slave_en;
  logic [31:0] slave_dat;

  // WAIT_CYCLES=3 instance
  logic        b_m0_req, b_m0_rw, b_m1_req, b_m1_rw;
  logic [31:0] b_m0_address, b_m0_wdata, b_m1_address, b_m1_wdata;
  logic [1:0]  b_m0_mode, b_m1_mode;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_data_address;
  logic        b_m0_ack, b_m1_ack, b_data_cs, b_data_rw;
  logic [1:0]  b_data_mode;
  wire  [31:0] b_data_bus;
  logic        b_slave_en;
  logic [31:0] b_slave_dat;

  assign data_bus   = slave_en   ? slave_dat   : 32'bz;
  assign b_data_bus = b_slave_en ? b_slave_dat : 32'bz;

  data_bus_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_mode(m0_mode), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_mode(m1_mode), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .data_address(data_address), .data_bus(data_bus), .data_cs(data_cs),
    .data_rw(data_rw), .data_mode(data_mode)
  );

  data_bus_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut_w3 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_address(b_m0_address), .m0_wdata(b_m0_wdata), .m0_rw(b_m0_rw),
    .m0_mode(b_m0_mode), .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_address(b_m1_address), .m1_wdata(b_m1_wdata), .m1_rw(b_m1_rw),
    .m1_mode(b_m1_mode), .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .data_address(b_data_address), .data_bus(b_data_bus), .data_cs(b_data_cs),
    .data_rw(b_data_rw), .data_mode(b_data_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Print and stop MMIO slaves plus an ack-exclusivity monitor, all on negedge.
  always @(negedge clk) begin
    if (data_cs && data_rw && data_address == 32'h2) begin
      print_chr <= data_bus[7:0];
      print_cnt <= print_cnt + 1;
    end
    if (data_cs && data_rw && data_address == 32'h1 && data_bus == 32'h1)
      stop_seen <= 1'b1;
    if (m0_ack && m1_ack)
      both_ack_cnt <= both_ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    both_ack_cnt = 0; print_cnt = 0; print_chr = 8'h00; stop_seen = 1'b0;
    rst = 1'b1;
    m0_req = 0; m0_rw = 0; m0_address = 0; m0_wdata = 0; m0_mode = 0;
    m1_req = 0; m1_rw = 0; m1_address = 0; m1_wdata = 0; m1_mode = 0;
    b_m0_req = 0; b_m0_rw = 0; b_m0_address = 0; b_m0_wdata = 0; b_m0_mode = 0;
    b_m1_req = 0; b_m1_rw = 0; b_m1_address = 0; b_m1_wdata = 0; b_m1_mode = 0;
    slave_en = 0; slave_dat = 0; b_slave_en = 0; b_slave_dat = 0;
    tick(); tick();

    chk("rst_cs", {31'd0, data_cs}, 32'd0);
    chk("rst_rw", {31'd0, data_rw}, 32'd0);
    chk("rst_mode", {30'd0, data_mode}, 32'd0);
    chk("rst_addr", data_address, 32'd0);
    chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    slave_en = 1; slave_dat = 32'h5A5A_0F0F; #1;
    chk("rst_bus_z", data_bus, 32'h5A5A_0F0F);
    slave_en = 0;
    rst = 1'b0;
    tick();

    // Single m0 write of 'A' to the print slave, mode passes through.
    m0_req = 1; m0_rw = 1; m0_address = 32'h2; m0_wdata = 32'h41; m0_mode = 2'b10;
    tick();
    chk("w1_cs_on", {31'd0, data_cs}, 32'd1);
    chk("w1_bus", data_bus, 32'h41);
    chk("w1_addr", data_address, 32'h2);
    chk("w1_mode", {30'd0, data_mode}, 32'd2);
    chk("w1_ack_early", {31'd0, m0_ack}, 32'd0);
    tick();
    chk("w1_cs_off", {31'd0, data_cs}, 32'd0);
    chk("w1_ack", {30'd0, m0_ack, m1_ack}, 32'b10);
    m0_req = 0;
    tick();
    chk("w1_ack_clr", {31'd0, m0_ack}, 32'd0);
    chk("print_chr", {24'd0, print_chr}, 32'h41);
    chk("print_cnt", print_cnt, 32'd1);
    chk("w1_rdata_keep", m0_rdata, 32'd0);

    // Back-to-back m0 writes: one transfer every 3 clocks.
    m0_req = 1; m0_address = 32'h30; m0_wdata = 32'h1234; m0_mode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("b2b_cs%0d", i), {31'd0, data_cs}, {31'd0, (i % 3) == 0});
      chk($sformatf("b2b_ack%0d", i), {31'd0, m0_ack}, {31'd0, (i % 3) == 1});
    end
    m0_req = 0;
    tick();
    chk("b2b_idle", {31'd0, data_cs}, 32'd0);

    // m1 write aborted by reset mid-BUS.
    m1_req = 1; m1_rw = 1; m1_address = 32'h40; m1_wdata = 32'h0000_FFFF; m1_mode = 2'b11;
    tick();
    chk("abort_cs_on", {31'd0, data_cs}, 32'd1);
    rst = 1'b1; #1;
    chk("abort_cs_off", {31'd0, data_cs}, 32'd0);
    slave_en = 1; slave_dat = 32'h1234_0000; #1;
    chk("abort_bus_z", data_bus, 32'h1234_0000);
    slave_en = 0;
    m1_req = 0;
    tick();
    chk("abort_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("abort_mode", {30'd0, data_mode}, 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_no_ack2", {30'd0, m0_ack, m1_ack}, 32'd0);

    // Continuous contention: m0, m1, m0, m1.
    m0_req = 1; m0_rw = 1; m0_address = 32'h10; m0_wdata = 32'hA0;
    m1_req = 1; m1_rw = 1; m1_address = 32'h20; m1_wdata = 32'hB1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rr_addr%0d", t), data_address, (t % 2 == 0) ? 32'h10 : 32'h20);
      chk($sformatf("rr_bus%0d", t), data_bus, (t % 2 == 0) ? 32'hA0 : 32'hB1);
      tick();
      chk($sformatf("rr_ack%0d", t), {30'd0, m0_ack, m1_ack}, (t % 2 == 0) ? 32'b10 : 32'b01);
      tick();
    end
    m0_req = 0; m1_req = 0;
    tick();
    chk("rr_never_both", both_ack_cnt, 32'd0);

    // m1 read on the WAIT_CYCLES=3 instance with mid-transfer request changes.
    b_m1_req = 1; b_m1_rw = 0; b_m1_address = 32'h100; b_m1_wdata = 32'h0000_FFFF; b_m1_mode = 2'b10;
    tick();
    chk("rd_cs0", {31'd0, b_data_cs}, 32'd1);
    b_slave_en = 1; b_slave_dat = 32'hDEAD_BEEF; #1;
    chk("rd_bus_slave", b_data_bus, 32'hDEAD_BEEF);
    tick();
    chk("rd_cs1", {31'd0, b_data_cs}, 32'd1);
    b_m1_address = 32'h200; b_m1_req = 0;
    tick();
    chk("rd_cs2", {31'd0, b_data_cs}, 32'd1);
    chk("rd_addr_latched", b_data_address, 32'h100);
    chk("rd_ack_early", {31'd0, b_m1_ack}, 32'd0);
    tick();
    chk("rd_cs_off", {31'd0, b_data_cs}, 32'd0);
    chk("rd_ack", {30'd0, b_m0_ack, b_m1_ack}, 32'b01);
    chk("rd_rdata1", b_m1_rdata, 32'hDEAD_BEEF);
    chk("rd_rdata0", b_m0_rdata, 32'd0);
    b_slave_en = 0;
    tick();
    chk("rd_ack_clr", {31'd0, b_m1_ack}, 32'd0);
    chk("rd_rdata_hold", b_m1_rdata, 32'hDEAD_BEEF);
    chk("rd_idle", {31'd0, b_data_cs}, 32'd0);

    // Stop slave: m0 writes 1 to address 1.
    m0_req = 1; m0_rw = 1; m0_address = 32'h1; m0_wdata = 32'h1; m0_mode = 2'b00;
    tick();
    chk("stop_pre", {31'd0, stop_seen}, 32'd0);
    tick();
    chk("stop_seen", {31'd0, stop_seen}, 32'd1);
    chk("stop_ack", {31'd0, m0_ack}, 32'd1);
    m0_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single core-side data bus (data_address / data_bus / data_cs / data_rw / data_mode) between two requesters: m0 (CPU data port) and m1 (debug/loader port).
- Arbitrates round-robin and sequences each transfer through a fixed number of bus cycles.
- Captures read data and returns a one-cycle ack to the granted requester.
- Sits between the requesters and all data-bus slaves (RAM, print/stop MMIO and others). Slaves sample on negedge clk.

Parameters:
- WAIT_CYCLES, 1, clocks data_cs is held per transfer; legal range 1..15.
- CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  m0 transfer request; level, held until m0_ack.
- m0_address  input  32  m0 address.
- m0_wdata  input  32  m0 write data.
- m0_rw  input  1  1 = write, 0 = read.
- m0_mode  input  2  access size code, passed through unchanged.
- m0_rdata  output  32  read data; valid in the m0_ack cycle, held until next m0 read.
- m0_ack  output  1  one-cycle completion pulse.
- m1_req, m1_address, m1_wdata, m1_rw, m1_mode, m1_rdata, m1_ack: same as m0.
- data_address  output  32  shared bus address.
- data_bus  inout  32  shared bidirectional data.
- data_cs  output  1  bus chip select.
- data_rw  output  1  bus direction, 1 = write.
- data_mode  output  2  bus access size.

Behaviour:
- Clock and reset: clk is the single clock. rst is asynchronous, active-high.
- Reset values: state=IDLE, data_cs=0, data_rw=0, data_mode=0, data_address=0, data_bus=Z, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, cnt=0, last_grant=1 (so m0 wins the first tie).
- States:
  - IDLE: if any req is high at posedge, choose a winner and latch its address, wdata, rw and mode into bus registers. Set data_cs=1, cnt=WAIT_CYCLES-1, go to BUS. With no req, stay in IDLE.
  - BUS: data_cs=1 and bus outputs stable.
    - If cnt!=0: decrement.
    - If cnt==0 at posedge: if the transfer is a read, capture data_bus into the winner's rdata. Clear data_cs, pulse the winner's ack, update last_grant, go to DONE.
  - DONE: ack=1 for exactly this cycle. Next posedge clears ack and returns to IDLE. There is no arbitration in DONE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins, so the winner alternates under contention.
- data_bus drive: driven with latched wdata only when state==BUS, data_cs=1 and data_rw=1; otherwise Z.
- Latency: req sampled at edge E0 -> data_cs high E0..E0+WAIT_CYCLES -> ack high between E0+WAIT_CYCLES and E0+WAIT_CYCLES+1. Peak throughput is one transfer per WAIT_CYCLES+2 clocks.
- Boundary conditions:
  - A req still high in the cycle after ack is a new request; requesters drop req on seeing ack.
  - Req deasserted mid-transfer is ignored; the transfer completes and ack still pulses.
  - A request change on the granted port during BUS has no effect, because values are latched.
  - Losing requester: its req stays pending and is served next IDLE.
  - data_mode is never altered by the arbiter.
  - rst mid-transfer: immediate abort to reset values, data_bus released to Z, no ack for the aborted transfer.
  - A winner's rdata is unchanged on writes. The non-winner's rdata is never touched.

Test Plan:
- Single m0 write addr=2, wdata=0x41, WAIT_CYCLES=1 -> data_cs high 1 clk, data_bus=0x41 during cs, m0_ack 1 clk, print slave outputs 'A'.
- Single m1 read addr=0x100, slave returns 0xDEADBEEF, WAIT_CYCLES=3 -> data_cs high 3 clks, data_bus Z from arbiter, m1_rdata=0xDEADBEEF in m1_ack cycle, m0_rdata stays 0.
- m0 and m1 both request continuously for 4 transfers -> grant order m0, m1, m0, m1; one ack per transfer, never both acks together.
- m0 requests back-to-back writes with m1 idle -> transfers start every WAIT_CYCLES+2 clocks, last_grant irrelevant.
- rst asserted mid-BUS of an m1 write -> data_cs=0 and data_bus=Z immediately, no m1_ack; after release, first tie goes to m0.
- m0 write addr=1, wdata=1 -> stop slave ends simulation at the negedge inside the cs window.
